// File: rtl/tick_reaction_timer_pkg.sv
// rtl/tick_reaction_timer_pkg.sv - shared round-state encoding and tick watchdog defaults
package tick_reaction_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } round_state_e;

  // 100 MHz clk with a nominal 40000-cycle tick period, plus a little slack
  localparam int unsigned GAP_MAX_DEFAULT = 40002;
  localparam int unsigned GAP_W_DEFAULT   = 17;

endpackage

// File: rtl/tick_watchdog.sv
// rtl/tick_watchdog.sv - tick edge detect and stalled-divider supervisor
module tick_watchdog
  import tick_reaction_timer_pkg::*;
#(
  parameter int unsigned GAP_MAX = GAP_MAX_DEFAULT,
  parameter int unsigned GAP_W   = GAP_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  output logic tick_rise,
  output logic tick_err
);

  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(GAP_MAX);

  logic             tick_q;
  logic [GAP_W-1:0] gap;
  logic [GAP_W-1:0] gap_next;

  assign tick_rise = tick & ~tick_q;

  always_comb begin
    gap_next = gap;
    if (tick_rise) begin
      gap_next = '0;
    end else if (gap != GAP_LIM) begin
      gap_next = gap + 1'b1;
    end
  end

  // tick_err is sticky: only rst_n clears it, even once ticks resume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q   <= 1'b0;
      gap      <= '0;
      tick_err <= 1'b0;
    end else begin
      tick_q <= tick;
      gap    <= gap_next;
      if (gap_next == GAP_LIM) begin
        tick_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_reaction_timer.sv
// rtl/tick_reaction_timer.sv - counts tick strobes between round start and hit, or times out
module tick_reaction_timer
  import tick_reaction_timer_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned GAP_MAX = GAP_MAX_DEFAULT,
  parameter int unsigned GAP_W   = GAP_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic [CNT_W-1:0] limit,
  input  logic             hit,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] reaction,
  output logic             tick_err
);

  round_state_e     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] lim, lim_n;
  logic [CNT_W-1:0] reaction_n;
  logic             timeout_n;
  logic             done_n;
  logic [CNT_W:0]   cnt_inc;
  logic             tick_rise;

  tick_watchdog #(
    .GAP_MAX(GAP_MAX),
    .GAP_W  (GAP_W)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .tick_rise(tick_rise),
    .tick_err (tick_err)
  );

  // one extra bit so limit = all-ones compares without wrapping
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign busy    = (state == ST_RUN);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    lim_n      = lim;
    reaction_n = reaction;
    timeout_n  = timeout;
    done_n     = 1'b0;
    case (state)
      ST_RUN: begin
        if (hit) begin
          state_n    = ST_DONE;
          reaction_n = cnt;
          timeout_n  = 1'b0;
          done_n     = 1'b1;
        end else if (lim == '0) begin
          state_n    = ST_DONE;
          reaction_n = '0;
          timeout_n  = 1'b1;
          done_n     = 1'b1;
        end else if (tick_rise) begin
          if (cnt_inc == {1'b0, lim}) begin
            state_n    = ST_DONE;
            reaction_n = lim;
            timeout_n  = 1'b1;
            done_n     = 1'b1;
          end else begin
            cnt_n = cnt_inc[CNT_W-1:0];
          end
        end
      end
      default: begin
        // IDLE and DONE behave alike: hold results until the next start
        if (start) begin
          state_n   = ST_RUN;
          cnt_n     = '0;
          lim_n     = limit;
          timeout_n = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lim      <= '0;
      reaction <= '0;
      timeout  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      lim      <= lim_n;
      reaction <= reaction_n;
      timeout  <= timeout_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_tick_reaction_timer.sv
// tb/tb_tick_reaction_timer.sv - scenario and randomized checks for tick_reaction_timer
module tb_tick_reaction_timer;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       start;
  logic [7:0] limit;
  logic       hit;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [7:0] reaction;
  logic       tick_err;

  int n_tests;
  int n_fail;

  tick_reaction_timer #(
    .CNT_W  (8),
    .GAP_MAX(50),
    .GAP_W  (7)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .start   (start),
    .limit   (limit),
    .hit     (hit),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .reaction(reaction),
    .tick_err(tick_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic begin_round(input logic [7:0] lim);
    limit = lim;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick = 1'b0; start = 1'b0; hit = 1'b0; limit = 8'd0;
    step(); step();
    if (busy !== 1'b0) begin $display("FAIL rst_busy: got %0b want 0", busy); n_fail++; end n_tests++;
    if (done !== 1'b0) begin $display("FAIL rst_done: got %0b want 0", done); n_fail++; end n_tests++;
    if (timeout !== 1'b0) begin $display("FAIL rst_timeout: got %0b want 0", timeout); n_fail++; end n_tests++;
    if (reaction !== 8'd0) begin $display("FAIL rst_reaction: got %0d want 0", reaction); n_fail++; end n_tests++;
    if (tick_err !== 1'b0) begin $display("FAIL rst_tick_err: got %0b want 0", tick_err); n_fail++; end n_tests++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_hit();
    begin_round(8'd5);
    if (busy !== 1'b1) begin $display("FAIL hit_busy_start: got %0b want 1", busy); n_fail++; end n_tests++;
    repeat (3) tick_pulse();
    hit = 1'b1;
    step();
    hit = 1'b0;
    if (done !== 1'b1) begin $display("FAIL hit_done: got %0b want 1", done); n_fail++; end n_tests++;
    if (busy !== 1'b0) begin $display("FAIL hit_busy_end: got %0b want 0", busy); n_fail++; end n_tests++;
    if (reaction !== 8'd3) begin $display("FAIL hit_reaction: got %0d want 3", reaction); n_fail++; end n_tests++;
    if (timeout !== 1'b0) begin $display("FAIL hit_timeout: got %0b want 0", timeout); n_fail++; end n_tests++;
    step();
    if (done !== 1'b0) begin $display("FAIL hit_done_pulse: got %0b want 0", done); n_fail++; end n_tests++;
    if (reaction !== 8'd3) begin $display("FAIL hit_reaction_hold: got %0d want 3", reaction); n_fail++; end n_tests++;
  endtask

  task automatic test_timeout();
    begin_round(8'd4);
    repeat (3) tick_pulse();
    if (busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL to_before_last: got busy=%0b done=%0b want busy=1 done=0", busy, done); n_fail++;
    end n_tests++;
    tick = 1'b1;
    step();
    tick = 1'b0;
    if (done !== 1'b1) begin $display("FAIL to_done: got %0b want 1", done); n_fail++; end n_tests++;
    if (timeout !== 1'b1) begin $display("FAIL to_timeout: got %0b want 1", timeout); n_fail++; end n_tests++;
    if (reaction !== 8'd4) begin $display("FAIL to_reaction: got %0d want 4", reaction); n_fail++; end n_tests++;
    if (busy !== 1'b0) begin $display("FAIL to_busy: got %0b want 0", busy); n_fail++; end n_tests++;
    step();
  endtask

  task automatic test_simultaneous();
    begin_round(8'd2);
    tick_pulse();
    tick = 1'b1; hit = 1'b1;
    step();
    tick = 1'b0; hit = 1'b0;
    if (done !== 1'b1) begin $display("FAIL sim_done: got %0b want 1", done); n_fail++; end n_tests++;
    if (timeout !== 1'b0) begin $display("FAIL sim_timeout: got %0b want 0", timeout); n_fail++; end n_tests++;
    if (reaction !== 8'd1) begin $display("FAIL sim_reaction: got %0d want 1", reaction); n_fail++; end n_tests++;
    step();
  endtask

  task automatic test_held_tick();
    begin_round(8'd3);
    tick = 1'b1;
    repeat (10) step();
    tick = 1'b0;
    step();
    if (busy !== 1'b1) begin $display("FAIL held_busy: got %0b want 1", busy); n_fail++; end n_tests++;
    start = 1'b1;
    step();
    start = 1'b0;
    tick_pulse();
    if (busy !== 1'b1) begin $display("FAIL restart_busy: got %0b want 1", busy); n_fail++; end n_tests++;
    hit = 1'b1;
    step();
    hit = 1'b0;
    if (reaction !== 8'd2) begin $display("FAIL restart_reaction: got %0d want 2", reaction); n_fail++; end n_tests++;
    if (timeout !== 1'b0) begin $display("FAIL restart_timeout: got %0b want 0", timeout); n_fail++; end n_tests++;
    step();
    begin_round(8'd0);
    if (busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL zero_first: got busy=%0b done=%0b want busy=1 done=0", busy, done); n_fail++;
    end n_tests++;
    step();
    if (done !== 1'b1) begin $display("FAIL zero_done: got %0b want 1", done); n_fail++; end n_tests++;
    if (timeout !== 1'b1) begin $display("FAIL zero_timeout: got %0b want 1", timeout); n_fail++; end n_tests++;
    if (reaction !== 8'd0) begin $display("FAIL zero_reaction: got %0d want 0", reaction); n_fail++; end n_tests++;
    if (busy !== 1'b0) begin $display("FAIL zero_busy: got %0b want 0", busy); n_fail++; end n_tests++;
    step();
  endtask

  task automatic test_watchdog();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int p = 0; p < 8; p++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      repeat (9) step();
    end
    if (tick_err !== 1'b0) begin $display("FAIL wd_steady: got %0b want 0", tick_err); n_fail++; end n_tests++;
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (45) step();
    if (tick_err !== 1'b0) begin $display("FAIL wd_gap45: got %0b want 0", tick_err); n_fail++; end n_tests++;
    repeat (15) step();
    if (tick_err !== 1'b1) begin $display("FAIL wd_gap60: got %0b want 1", tick_err); n_fail++; end n_tests++;
    repeat (5) tick_pulse();
    if (tick_err !== 1'b1) begin $display("FAIL wd_sticky: got %0b want 1", tick_err); n_fail++; end n_tests++;
    #2 rst_n = 1'b0;
    #1;
    if (tick_err !== 1'b0) begin $display("FAIL wd_async_clear: got %0b want 0", tick_err); n_fail++; end n_tests++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_round();
    begin_round(8'd10);
    repeat (2) tick_pulse();
    hit = 1'b1;
    step();
    hit = 1'b0;
    if (reaction !== 8'd2) begin $display("FAIL mid_pre_reaction: got %0d want 2", reaction); n_fail++; end n_tests++;
    begin_round(8'd10);
    repeat (3) tick_pulse();
    #2 rst_n = 1'b0;
    #1;
    if (busy !== 1'b0) begin $display("FAIL mid_busy: got %0b want 0", busy); n_fail++; end n_tests++;
    if (reaction !== 8'd0) begin $display("FAIL mid_reaction: got %0d want 0", reaction); n_fail++; end n_tests++;
    step();
    if (done !== 1'b0) begin $display("FAIL mid_no_done: got %0b want 0", done); n_fail++; end n_tests++;
    rst_n = 1'b1;
    step();
    begin_round(8'd1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    if (done !== 1'b1 || timeout !== 1'b1 || reaction !== 8'd1) begin
      $display("FAIL mid_next_round: got done=%0b timeout=%0b reaction=%0d want 1 1 1", done, timeout, reaction);
      n_fail++;
    end n_tests++;
    step();
  endtask

  // Reference: count tick rising edges since start; the round closes at the
  // first hit (reporting the count) or when the count reaches the limit.
  task automatic test_random();
    bit m_busy, m_to, m_done, m_tickq, rise;
    int m_cnt, m_lim, m_react;
    rst_n = 1'b0;
    tick = 1'b0; start = 1'b0; hit = 1'b0; limit = 8'd0;
    step();
    rst_n = 1'b1;
    m_busy = 0; m_to = 0; m_done = 0; m_tickq = 0; m_cnt = 0; m_lim = 0; m_react = 0;
    for (int c = 0; c < 1500; c++) begin
      tick  = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 9) == 0);
      hit   = ($urandom_range(0, 11) == 0);
      limit = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
      rise = tick && !m_tickq;
      m_tickq = tick;
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_cnt = 0; m_lim = int'(limit); m_to = 0;
        end
      end else if (hit) begin
        m_busy = 0; m_react = m_cnt; m_to = 0; m_done = 1;
      end else if (m_lim == 0) begin
        m_busy = 0; m_react = 0; m_to = 1; m_done = 1;
      end else if (rise) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == m_lim) begin
          m_busy = 0; m_react = m_lim; m_to = 1; m_done = 1;
        end
      end
      step();
      if (busy !== m_busy || done !== m_done || timeout !== m_to || reaction !== 8'(m_react)) begin
        $display("FAIL rand_cycle%0d: got busy=%0b done=%0b timeout=%0b reaction=%0d want %0b %0b %0b %0d",
                 c, busy, done, timeout, reaction, m_busy, m_done, m_to, m_react);
        n_fail++;
      end
      n_tests++;
    end
    tick = 1'b0; start = 1'b0; hit = 1'b0;
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; hit = 1'b0; limit = 8'd0;
    test_reset();
    test_hit();
    test_timeout();
    test_simultaneous();
    test_held_tick();
    test_watchdog();
    test_reset_mid_round();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
